// File: rtl/labft_pkg.sv
// LABFT checker shared definitions.
// Width helpers, lane count and the pairing FSM encoding.
package labft_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACC = 2'd1,
        WAIT_DOT = 2'd2,
        PAIR     = 2'd3
    } checker_state_t;

    function automatic int dot_bits(input int in_bits, input int n);
        return 2 * (in_bits + n) + n;
    endfunction

    function automatic int acc_bits(input int in_bits, input int n);
        return 2 * in_bits + 3 * n;
    endfunction

    function automatic int cmp_bits(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/labft_cmp_lane.sv
// One checksum lane: zero-extend both sides and compare.
// The mismatch bit is registered when a compare is pending.
module labft_cmp_lane
    import labft_pkg::*;
#(
    parameter int dotBits = 28,
    parameter int accBits = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [dotBits-1:0] dot,
    input  logic [accBits-1:0] acc,
    output logic               diff,
    output logic               mismatch
);

    localparam int cmpBits = cmp_bits(dotBits, accBits);

    logic [cmpBits-1:0] dot_ext;
    logic [cmpBits-1:0] acc_ext;

    assign dot_ext = cmpBits'(dot);
    assign acc_ext = cmpBits'(acc);
    assign diff    = (dot_ext != acc_ext);

    // Hold the last compare result until the next compare.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mismatch <= 1'b0;
        end else if (en) begin
            mismatch <= diff;
        end
    end

endmodule

// File: rtl/labft_checker.sv
// LABFT final compare stage.
// Pairs predicted and observed checksum sets and reports mismatches.
module labft_checker
    import labft_pkg::*;
#(
    parameter int inputBits     = 8,
    parameter int arraySize     = 4,
    parameter int dotBits       = dot_bits(inputBits, arraySize),
    parameter int accBits       = acc_bits(inputBits, arraySize),
    parameter int timeoutCycles = 64,
    parameter int countBits     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dotValid,
    input  logic [dotBits-1:0]   ae_dot,
    input  logic [dotBits-1:0]   be_dot,
    input  logic [dotBits-1:0]   ce_dot,
    input  logic [dotBits-1:0]   de_dot,
    input  logic                 accValid,
    input  logic [accBits-1:0]   w_acc,
    input  logic [accBits-1:0]   x_acc,
    input  logic [accBits-1:0]   y_acc,
    input  logic [accBits-1:0]   z_acc,
    input  logic                 clearErrors,
    output logic [3:0]           error,
    output logic                 errorValid,
    output logic [3:0]           errorSticky,
    output logic [countBits-1:0] mismatchCount,
    output logic                 timeout,
    output logic                 overrun
);

    localparam int tmoBits = (timeoutCycles > 2) ? $clog2(timeoutCycles) : 1;
    localparam logic [tmoBits-1:0] TMO_LAST = tmoBits'(timeoutCycles - 1);
    localparam bit TMO_EN = (timeoutCycles != 0);

    logic [dotBits-1:0] dot_in   [NUM_LANES];
    logic [accBits-1:0] acc_in   [NUM_LANES];
    logic [dotBits-1:0] dot_hold [NUM_LANES];
    logic [accBits-1:0] acc_hold [NUM_LANES];
    logic [dotBits-1:0] cmp_dot  [NUM_LANES];
    logic [accBits-1:0] cmp_acc  [NUM_LANES];

    logic               dot_held;
    logic               acc_held;
    logic               cmp_pending;
    logic [tmoBits-1:0] tmo_cnt;
    checker_state_t     state;

    logic               pair;
    logic               waiting;
    logic               dot_take;
    logic               acc_take;
    logic               dot_ovr;
    logic               acc_ovr;
    logic               tmo_fire;
    logic [3:0]         diff;

    assign dot_in[0] = ae_dot;
    assign dot_in[1] = be_dot;
    assign dot_in[2] = ce_dot;
    assign dot_in[3] = de_dot;
    assign acc_in[0] = w_acc;
    assign acc_in[1] = x_acc;
    assign acc_in[2] = y_acc;
    assign acc_in[3] = z_acc;

    // Pairing state is a pure function of the two hold flags.
    always_comb begin
        state = IDLE;
        unique case ({dot_held, acc_held})
            2'b00:   state = IDLE;
            2'b10:   state = WAIT_ACC;
            2'b01:   state = WAIT_DOT;
            default: state = PAIR;
        endcase
    end

    assign pair     = (state == PAIR);
    assign waiting  = (state == WAIT_ACC) || (state == WAIT_DOT);
    assign dot_take = dotValid && (!dot_held || pair);
    assign acc_take = accValid && (!acc_held || pair);
    assign dot_ovr  = dotValid && dot_held && !pair;
    assign acc_ovr  = accValid && acc_held && !pair;
    assign tmo_fire = TMO_EN && (tmo_cnt == TMO_LAST) &&
                      (((state == WAIT_ACC) && !accValid) ||
                       ((state == WAIT_DOT) && !dotValid));

    // Hold flags and compare-pending flag; a freed slot refills on the pair edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dot_held    <= 1'b0;
            acc_held    <= 1'b0;
            cmp_pending <= 1'b0;
        end else begin
            cmp_pending <= pair;
            if (pair) begin
                dot_held <= dotValid;
                acc_held <= accValid;
            end else begin
                if (dot_take) begin
                    dot_held <= 1'b1;
                end else if (tmo_fire) begin
                    dot_held <= 1'b0;
                end
                if (acc_take) begin
                    acc_held <= 1'b1;
                end else if (tmo_fire) begin
                    acc_held <= 1'b0;
                end
            end
        end
    end

    // Data capture into hold registers and copy into the compare stage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (dot_take) begin
                dot_hold[i] <= dot_in[i];
            end
            if (acc_take) begin
                acc_hold[i] <= acc_in[i];
            end
            if (pair) begin
                cmp_dot[i] <= dot_hold[i];
                cmp_acc[i] <= acc_hold[i];
            end
        end
    end

    // Wait counter runs only while exactly one side is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (waiting && !tmo_fire) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        labft_cmp_lane #(
            .dotBits (dotBits),
            .accBits (accBits)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (cmp_pending),
            .dot      (cmp_dot[g]),
            .acc      (cmp_acc[g]),
            .diff     (diff[g]),
            .mismatch (error[g])
        );
    end

    // Status outputs; a clear lands before a coincident result is merged in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            errorValid    <= 1'b0;
            errorSticky   <= '0;
            mismatchCount <= '0;
            timeout       <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            errorValid <= cmp_pending;
            timeout    <= tmo_fire;
            if (clearErrors) begin
                errorSticky   <= '0;
                mismatchCount <= '0;
                overrun       <= 1'b0;
            end
            if (cmp_pending) begin
                errorSticky <= (clearErrors ? 4'b0000 : errorSticky) | diff;
                if (|diff) begin
                    if (clearErrors) begin
                        mismatchCount <= countBits'(1);
                    end else if (mismatchCount != '1) begin
                        mismatchCount <= mismatchCount + 1'b1;
                    end
                end
            end
            if (dot_ovr || acc_ovr) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_labft_checker.sv
// Scoreboard bench for labft_checker.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_labft_checker;

    localparam int DW = 28;
    localparam int AW = 28;
    localparam int CW = 16;

    typedef struct {
        logic [3:0]    err;
        logic [3:0]    stk;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          dotValid;
    logic [DW-1:0] ae_dot, be_dot, ce_dot, de_dot;
    logic          accValid;
    logic [AW-1:0] w_acc, x_acc, y_acc, z_acc;
    logic          clearErrors;
    logic [3:0]    error;
    logic          errorValid;
    logic [3:0]    errorSticky;
    logic [CW-1:0] mismatchCount;
    logic          timeout;
    logic          overrun;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    labft_checker #(
        .inputBits     (8),
        .arraySize     (4),
        .dotBits       (DW),
        .accBits       (AW),
        .timeoutCycles (8),
        .countBits     (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dotValid      (dotValid),
        .ae_dot        (ae_dot),
        .be_dot        (be_dot),
        .ce_dot        (ce_dot),
        .de_dot        (de_dot),
        .accValid      (accValid),
        .w_acc         (w_acc),
        .x_acc         (x_acc),
        .y_acc         (y_acc),
        .z_acc         (z_acc),
        .clearErrors   (clearErrors),
        .error         (error),
        .errorValid    (errorValid),
        .errorSticky   (errorSticky),
        .mismatchCount (mismatchCount),
        .timeout       (timeout),
        .overrun       (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] er, input logic [3:0] st,
                        input logic [CW-1:0] cn);
        exp_t e;
        e.err = er;
        e.stk = st;
        e.cnt = cn;
        q.push_back(e);
    endtask

    task automatic set_dot(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input logic [DW-1:0] d);
        dotValid = 1'b1;
        ae_dot = a;
        be_dot = b;
        ce_dot = c;
        de_dot = d;
    endtask

    task automatic set_acc(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] c, input logic [AW-1:0] d);
        accValid = 1'b1;
        w_acc = a;
        x_acc = b;
        y_acc = c;
        z_acc = d;
    endtask

    task automatic idle();
        dotValid = 1'b0;
        accValid = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_errorValid"}, 32'(errorValid), 32'd0);
        chk({tag, "_sticky"}, 32'(errorSticky), 32'd0);
        chk({tag, "_count"}, 32'(mismatchCount), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    // Monitor: every errorValid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (errorValid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_errorValid: got error=%b expected none",
                         error);
            end else begin
                mon_e = q.pop_front();
                chk("sb_error", 32'(error), 32'(mon_e.err));
                chk("sb_sticky", 32'(errorSticky), 32'(mon_e.stk));
                chk("sb_count", 32'(mismatchCount), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int seen;
        int tcyc;
        logic [3:0] er;
        logic [3:0] st;
        logic [CW-1:0] cn;

        rst = 1'b0;
        clearErrors = 1'b0;
        idle();
        set_dot(0, 0, 0, 0);
        set_acc(0, 0, 0, 0);
        idle();
        wait_n(3);
        chk_all_zero("reset");
        rst = 1'b1;
        wait_n(2);

        // Dot first, acc three cycles later, equal values.
        set_dot(100, 200, 300, 400);
        @(negedge clk) idle();
        wait_n(2);
        set_acc(100, 200, 300, 400);
        push(4'b0000, 4'b0000, 0);
        @(negedge clk) idle();
        @(negedge clk);
        chk("latency_early", 32'(errorValid), 32'd0);
        @(negedge clk);
        chk("latency", 32'(errorValid), 32'd1);
        wait_n(3);

        // Acc first.
        set_acc(100, 200, 300, 400);
        @(negedge clk) idle();
        wait_n(2);
        set_dot(100, 200, 300, 400);
        push(4'b0000, 4'b0000, 0);
        @(negedge clk) idle();
        wait_n(4);

        // Single-lane fault on lane 2, then a good pair.
        set_dot(100, 200, 300, 400);
        set_acc(100, 200, 301, 400);
        push(4'b0100, 4'b0100, 1);
        @(negedge clk) idle();
        wait_n(3);
        set_dot(100, 200, 300, 400);
        set_acc(100, 200, 300, 400);
        push(4'b0000, 4'b0100, 1);
        @(negedge clk) idle();
        wait_n(4);

        // Overrun: second dot ignored, first value is compared.
        set_dot(1, 2, 3, 4);
        @(negedge clk) set_dot(5, 6, 7, 8);
        @(negedge clk) idle();
        @(negedge clk) set_acc(1, 2, 3, 4);
        push(4'b0000, 4'b0100, 1);
        @(negedge clk) idle();
        wait_n(4);
        chk("overrun_set", 32'(overrun), 32'd1);
        clearErrors = 1'b1;
        @(negedge clk) clearErrors = 1'b0;
        chk("clear_overrun", 32'(overrun), 32'd0);
        chk("clear_sticky", 32'(errorSticky), 32'd0);
        chk("clear_count", 32'(mismatchCount), 32'd0);
        wait_n(2);

        // Timeout with only the dot side presented.
        t0 = cyc;
        set_dot(9, 9, 9, 9);
        @(negedge clk) idle();
        seen = 0;
        tcyc = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                seen++;
                tcyc = cyc;
            end
        end
        chk("timeout_pulses", 32'(seen), 32'd1);
        chk("timeout_cycle", 32'(tcyc - t0), 32'd9);
        chk("timeout_sticky", 32'(errorSticky), 32'd0);
        // A fresh acc-only set must not pair with the dropped dot.
        set_acc(7, 7, 7, 7);
        @(negedge clk) idle();
        wait_n(3);
        set_dot(7, 7, 7, 7);
        push(4'b0000, 4'b0000, 0);
        @(negedge clk) idle();
        wait_n(4);

        // Back-to-back pairs, lane 1 bad on the 3rd and 7th.
        for (int i = 0; i < 10; i++) begin
            set_dot(DW'(10 + i), DW'(20 + i), DW'(30 + i), DW'(40 + i));
            set_acc(AW'(10 + i),
                    AW'(20 + i + ((i == 2 || i == 6) ? 1 : 0)),
                    AW'(30 + i), AW'(40 + i));
            er = (i == 2 || i == 6) ? 4'b0010 : 4'b0000;
            st = (i >= 2) ? 4'b0010 : 4'b0000;
            cn = (i >= 6) ? CW'(2) : ((i >= 2) ? CW'(1) : CW'(0));
            push(er, st, cn);
            @(negedge clk);
        end
        idle();
        wait_n(4);
        chk("b2b_overrun", 32'(overrun), 32'd0);
        chk("b2b_count", 32'(mismatchCount), 32'd2);

        // Clear coincident with a lane-0 mismatch result.
        set_dot(100, 200, 300, 400);
        set_acc(101, 200, 300, 400);
        push(4'b0001, 4'b0001, 1);
        @(negedge clk) idle();
        @(negedge clk) clearErrors = 1'b1;
        @(negedge clk) clearErrors = 1'b0;
        wait_n(3);

        // Reset with the dot side held.
        set_dot(5, 5, 5, 5);
        @(negedge clk) idle();
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (timeout === 1'b1) seen++;
        end
        chk("midreset_no_timeout", 32'(seen), 32'd0);
        set_acc(5, 5, 5, 5);
        @(negedge clk) idle();
        wait_n(5);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/labft_checker.md
Name: labft_checker

Overview:
- Final compare stage of the LABFT 4x4 fault-tolerance datapath.
- Consumes the four predicted checksums (ae/be/ce/de dot products) from the dot stage and the four observed checksums (w/x/y/z accumulations) from the output-accumulator stage.
- The two sides may arrive in either order. The block buffers each side, pairs one set from each, compares the four lanes, and reports per-lane error, sticky flags, a mismatch count, and timeout/overrun status.

Parameters:
- inputBits, 8, operand width of the systolic array.
- arraySize, 4, array dimension (four lanes, fixed).
- dotBits, 2*(inputBits+arraySize)+arraySize (28), width of the predicted checksums.
- accBits, 2*inputBits+3*arraySize (28), width of the observed checksums.
- timeoutCycles, 64, maximum wait for the missing side; 0 disables the timeout.
- countBits, 16, width of the mismatch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- dotValid  in  1  one-cycle pulse: the ae/be/ce/de_dot inputs are valid.
- ae_dot, be_dot, ce_dot, de_dot  in  dotBits each  predicted checksums, lanes 0..3.
- accValid  in  1  one-cycle pulse: the w/x/y/z_acc inputs are valid.
- w_acc, x_acc, y_acc, z_acc  in  accBits each  observed checksums, lanes 0..3.
- clearErrors  in  1  clears errorSticky, mismatchCount and overrun.
- error  out  4  per-lane mismatch result of the last compare; bit0 = ae vs w … bit3 = de vs z.
- errorValid  out  1  one-cycle pulse: error is updated.
- errorSticky  out  4  OR of all error results since the last clear.
- mismatchCount  out  countBits  number of compares with any lane mismatching; saturating.
- timeout  out  1  one-cycle pulse: a pending side was discarded.
- overrun  out  1  sticky: a valid arrived for a side that was already held.

Behaviour:
- Reset (rst low at a clock edge):
  - All outputs go to 0.
  - Hold flags dotHeld/accHeld, the compare stage and the timeout counter are cleared.
- Capture:
  - dotValid high at an edge with dotHeld=0 latches the four dot values and sets dotHeld. accValid behaves the same way for the acc side.
  - A valid for a side that is already held is ignored (the first value wins) and sets overrun.
- Pairing:
  - At the first edge where dotHeld=accHeld=1, both held sets are copied into the compare registers, both flags clear, and cmpPending sets.
  - If a new valid for a side arrives on that same edge, it is captured into the freed hold register (flag stays 1). There is no overrun in this case.
  - Effective throughput is one pair per cycle.
- Compare:
  - In the cycle with cmpPending=1, each lane zero-extends both operands to max(dotBits, accBits) and tests for inequality.
  - At the next edge:
    - error is loaded with the result.
    - errorValid = 1 for exactly one cycle.
    - errorSticky |= result.
    - mismatchCount increments if the result is non-zero, saturating at all-ones.
- Latency: errorValid is asserted two edges after the edge that captured the later of the two valids.
- error holds its value between compares; it is not cleared by errorValid dropping.
- FSM, one per block; encoding in the package:
  - IDLE: neither side held.
  - WAIT_ACC: dot side held only.
  - WAIT_DOT: acc side held only.
  - PAIR: both held; copies to the compare stage on the next edge.
  - State is derived from the hold flags. The compare stage is a separate one-deep pipeline, so FSM and compare overlap.
- Timeout:
  - The counter increments each cycle in WAIT_ACC or WAIT_DOT and resets in IDLE or PAIR.
  - When it reaches timeoutCycles-1 and the missing valid is still absent that cycle: the held side is dropped (flag cleared), timeout pulses for 1 cycle, errorSticky is unchanged, and the counter resets.
  - A valid arriving on the timeout edge wins: pairing happens, there is no timeout.
- clearErrors:
  - Takes effect at the edge it is sampled.
  - If a compare result lands on the same edge, the clear applies first and the new result is then ORed/counted.
  - It does not affect held data, error or errorValid.
- Reset mid-operation discards held sets and any pending compare; no errorValid is produced for them.

Decomposition:
- labft_pkg:
  - Width functions for dotBits/accBits/cmpBits.
  - Lane-count constant NUM_LANES=4.
  - State enum checker_state_t {IDLE, WAIT_ACC, WAIT_DOT, PAIR}.
- Sub-module labft_cmp_lane: zero-extend and compare one lane, with a registered mismatch bit. Instantiated four times.

Test Plan:
- Pairing in either order:
  - dot (100,200,300,400) then accValid 3 cycles later with equal values -> errorValid 2 edges after accValid, error=0000, mismatchCount=0.
  - Repeat with acc first -> same result.
- Single-lane fault: simultaneous valids with y_acc=301 vs ce_dot=300 -> error=0100, errorSticky=0100, mismatchCount=1. Next good pair -> error=0000, errorSticky stays 0100.
- Overrun: dotValid twice with no acc between (values A then B), then acc = A -> overrun=1, compare uses A, error=0000.
- Timeout, timeoutCycles=8: dotValid only -> timeout pulse 8 cycles later, state IDLE. A following acc-only set is held, not paired with the stale dot.
- Back-to-back: both valids every cycle for 10 cycles, lane 1 mismatching on cycles 3 and 7 -> 10 errorValid pulses, mismatchCount=2, no overrun.
- clearErrors coincident with a mismatch result -> errorSticky equals the new result only, mismatchCount=1. Also: rst low with one side held -> all outputs 0, no later errorValid.
